// File: rtl/program_sequencer_q11_pkg.sv
// Shared constants for the Q11 program sequencer: address width, stall-FSM
// encodings, the stall NOP opcodes and the jump-target helper.
package program_sequencer_q11_pkg;

    localparam int PM_AW = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [7:0] NOP_C8 = 8'hC8;
    localparam logic [7:0] NOP_CF = 8'hCF;
    localparam logic [7:0] NOP_D8 = 8'hD8;
    localparam logic [7:0] NOP_DF = 8'hDF;

    // Jumps always land on a 16-byte page boundary.
    function automatic logic [PM_AW-1:0] jmp_target(input logic [3:0] nib);
        return {nib, 4'h0};
    endfunction

endpackage

// File: rtl/program_sequencer_q11_stall_timer.sv
// Stall FSM plus down-counter: freezes the decoder ir for `len` cycles after a
// trigger, then forces one RELEASE cycle so the stale NOP cannot retrigger.
module stall_timer
    import program_sequencer_q11_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             trig,
    input  logic [CNT_W-1:0] len,
    output logic             count_flag
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flag;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flag    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    flag    = 1'b1;
                    cnt_d   = len - CNT_W'(1);
                    state_d = (len == CNT_W'(1)) ? ST_RELEASE : ST_HOLD;
                end
            end
            ST_HOLD: begin
                flag  = 1'b1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    state_d = ST_RELEASE;
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Reset aborts a stall immediately, including the flag in the reset cycle.
    assign count_flag = flag & ~sync_reset;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/program_sequencer_q11.sv
// Q11 program sequencer: PC register and next-address mux feeding program
// memory, with the stall timer holding both PC and decoder ir during C8/D8 NOPs.
module program_sequencer_q11
    import program_sequencer_q11_pkg::*;
#(
    parameter int SHORT_HOLD = 4,
    parameter int LONG_HOLD  = 8,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             jmp,
    input  logic             jmp_nz,
    input  logic [3:0]       jmp_addr,
    input  logic             dont_jmp,
    input  logic             NOPC8,
    input  logic             NOPD8,
    output logic [PM_AW-1:0] pm_addr,
    output logic [PM_AW-1:0] pc,
    output logic             count_flag
);

    logic [PM_AW-1:0] pc_q;
    logic [CNT_W-1:0] stall_len;

    // C8 takes priority if the decoder ever flags both.
    assign stall_len = NOPC8 ? CNT_W'(SHORT_HOLD) : CNT_W'(LONG_HOLD);

    stall_timer #(.CNT_W(CNT_W)) u_stall (
        .clk        (clk),
        .sync_reset (sync_reset),
        .trig       (NOPC8 | NOPD8),
        .len        (stall_len),
        .count_flag (count_flag)
    );

    always_comb begin
        if (sync_reset)
            pm_addr = '0;
        else if (count_flag)
            pm_addr = pc_q;
        else if (jmp || (jmp_nz && !dont_jmp))
            pm_addr = jmp_target(jmp_addr);
        else
            pm_addr = pc_q + PM_AW'(1);
    end

    always_ff @(posedge clk) begin
        pc_q <= pm_addr;
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_program_sequencer_q11.sv
// Table-driven bench for program_sequencer_q11 with a scoreboard queue, plus a
// second instance built with SHORT_HOLD=1 for the single-cycle stall case.
module tb_program_sequencer_q11;

    typedef struct {
        logic       rst, jmp, jnz, dz, c8, d8;
        logic [3:0] addr;
        logic [7:0] pm;
        logic       cf;
        logic       chk_pc;
        logic [7:0] pcv;
    } vec_t;

    typedef struct {
        int         idx;
        logic [7:0] pm;
        logic       cf;
        logic       chk_pc;
        logic [7:0] pcv;
    } exp_t;

    logic       clk = 1'b0;
    logic       sync_reset, jmp, jmp_nz, dont_jmp, NOPC8, NOPD8;
    logic [3:0] jmp_addr;
    logic [7:0] pm_addr, pc;
    logic       count_flag;

    logic       rst1, c8_1;
    logic [7:0] pm1, pc1;
    logic       cf1;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    program_sequencer_q11 dut (
        .clk(clk), .sync_reset(sync_reset), .jmp(jmp), .jmp_nz(jmp_nz),
        .jmp_addr(jmp_addr), .dont_jmp(dont_jmp), .NOPC8(NOPC8), .NOPD8(NOPD8),
        .pm_addr(pm_addr), .pc(pc), .count_flag(count_flag)
    );

    program_sequencer_q11 #(.SHORT_HOLD(1), .LONG_HOLD(8), .CNT_W(4)) dut1 (
        .clk(clk), .sync_reset(rst1), .jmp(1'b0), .jmp_nz(1'b0),
        .jmp_addr(4'h0), .dont_jmp(1'b0), .NOPC8(c8_1), .NOPD8(1'b0),
        .pm_addr(pm1), .pc(pc1), .count_flag(cf1)
    );

    task automatic add(input logic rst, input logic j, input logic jn, input logic [3:0] a,
                       input logic dz, input logic c8, input logic d8,
                       input logic [7:0] pm, input logic cf, input logic cp, input logic [7:0] pcv);
        vec_t v;
        v.rst = rst; v.jmp = j; v.jnz = jn; v.addr = a; v.dz = dz; v.c8 = c8; v.d8 = d8;
        v.pm = pm; v.cf = cf; v.chk_pc = cp; v.pcv = pcv;
        vecs.push_back(v);
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        string tag;
        sync_reset = 1'b1; jmp = 0; jmp_nz = 0; dont_jmp = 0; NOPC8 = 0; NOPD8 = 0; jmp_addr = 0;
        rst1 = 1'b1; c8_1 = 1'b0;

        // reset, then sequential fetch
        add(1,0,0,0,0,0,0, 8'h00,0, 0,8'h00);
        add(1,0,0,0,0,0,0, 8'h00,0, 1,8'h00);
        add(1,0,0,0,0,0,0, 8'h00,0, 1,8'h00);
        add(0,0,0,0,0,0,0, 8'h01,0, 1,8'h00);
        add(0,0,0,0,0,0,0, 8'h02,0, 1,8'h01);
        add(0,1,0,4'h1,0,0,0, 8'h10,0, 1,8'h02);
        add(0,0,0,0,0,0,0, 8'h11,0, 1,8'h10);
        add(0,0,0,0,0,0,0, 8'h12,0, 1,8'h11);
        // jmp at pc=12
        add(0,1,0,4'hA,0,0,0, 8'hA0,0, 1,8'h12);
        add(0,0,0,0,0,0,0, 8'hA1,0, 1,8'hA0);
        // jmp_nz taken / suppressed at pc=30, jmp wins over jmp_nz
        add(0,1,0,4'h3,0,0,0, 8'h30,0, 1,8'hA1);
        add(0,0,1,4'h5,1,0,0, 8'h31,0, 1,8'h30);
        add(0,1,0,4'h3,0,0,0, 8'h30,0, 1,8'h31);
        add(0,0,1,4'h5,0,0,0, 8'h50,0, 1,8'h30);
        add(0,1,1,4'h7,1,0,0, 8'h70,0, 1,8'h50);
        add(0,0,1,4'h4,0,0,0, 8'h40,0, 1,8'h70);
        // NOPC8 at pc=40: 4 stall cycles (jmp inert), then release
        add(0,0,0,0,0,1,0, 8'h40,1, 1,8'h40);
        add(0,1,0,4'h9,0,1,0, 8'h40,1, 1,8'h40);
        add(0,0,0,0,0,1,0, 8'h40,1, 1,8'h40);
        add(0,0,0,0,0,1,0, 8'h40,1, 1,8'h40);
        add(0,0,0,0,0,1,0, 8'h41,0, 1,8'h40);
        add(0,0,0,0,0,0,0, 8'h42,0, 1,8'h41);
        // NOPD8 aborted by reset in third stall cycle
        add(0,0,0,0,0,0,1, 8'h42,1, 1,8'h42);
        add(0,0,0,0,0,0,1, 8'h42,1, 1,8'h42);
        add(1,0,0,0,0,0,1, 8'h00,0, 1,8'h42);
        add(0,0,0,0,0,0,0, 8'h01,0, 1,8'h00);
        // full NOPD8: 8 stall cycles then release
        for (int i = 0; i < 8; i++) add(0,0,0,0,0,0,1, 8'h01,1, 1,8'h01);
        add(0,0,0,0,0,0,1, 8'h02,0, 1,8'h01);
        // back-to-back retrigger with C8 and D8 both high: short length wins
        for (int i = 0; i < 4; i++) add(0,0,0,0,0,1,1, 8'h02,1, 1,8'h02);
        add(0,0,0,0,0,1,1, 8'h03,0, 1,8'h02);
        add(0,0,0,0,0,0,0, 8'h04,0, 1,8'h03);
        // wrap FF -> 00
        add(0,1,0,4'hF,0,0,0, 8'hF0,0, 1,8'h04);
        for (int i = 1; i <= 16; i++)
            add(0,0,0,0,0,0,0, 8'(8'hF0 + i), 0, 1, 8'(8'hF0 + i - 1));
        add(0,0,0,0,0,0,0, 8'h01,0, 1,8'h00);

        @(posedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            sync_reset = vecs[i].rst; jmp = vecs[i].jmp; jmp_nz = vecs[i].jnz;
            jmp_addr = vecs[i].addr; dont_jmp = vecs[i].dz;
            NOPC8 = vecs[i].c8; NOPD8 = vecs[i].d8;
            e.idx = i; e.pm = vecs[i].pm; e.cf = vecs[i].cf;
            e.chk_pc = vecs[i].chk_pc; e.pcv = vecs[i].pcv;
            sb.push_back(e);
            @(negedge clk);
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL scoreboard_empty at vector %0d", i);
            end else begin
                e = sb.pop_front();
                tag = $sformatf("v%0d", e.idx);
                chk8({tag, "_pm_addr"}, pm_addr, e.pm);
                chk1({tag, "_count_flag"}, count_flag, e.cf);
                if (e.chk_pc) chk8({tag, "_pc"}, pc, e.pcv);
            end
            @(posedge clk); #1;
        end
        sync_reset = 1'b0; jmp = 0; jmp_nz = 0; NOPC8 = 0; NOPD8 = 0;

        // SHORT_HOLD=1 instance: one stall cycle, release, then retrigger from IDLE
        @(posedge clk); #1;
        rst1 = 1'b0; c8_1 = 1'b1;
        @(negedge clk);
        chk1("h1_stall_cf", cf1, 1'b1);
        chk8("h1_stall_pm", pm1, 8'h00);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("h1_release_cf", cf1, 1'b0);
        chk8("h1_release_pm", pm1, 8'h01);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("h1_retrig_cf", cf1, 1'b1);
        chk8("h1_retrig_pm", pm1, 8'h01);
        chk8("h1_retrig_pc", pc1, 8'h01);
        @(posedge clk); #1;
        c8_1 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk1("h1_idle_cf", cf1, 1'b0);
        chk8("h1_idle_pm", pm1, 8'h03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
